ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem_pkg.sv | 36 +++
 rtl/ex_mem_if.sv | 46 ++++
 rtl/ex_mem.sv | 91 +++++++++
 tb/tb_ex_mem.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared pipeline defines: stall vector layout, write-enable levels, zero word and ALU/LSU op codes.
package ex_mem_pkg;

  localparam int unsigned STALL_W   = 6;
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 8;

  localparam logic [WORD_W-1:0] ZeroWord     = 32'h0000_0000;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;

  // Load/store op codes consumed by the MEM stage
  localparam logic [OP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [OP_W-1:0] EXE_LB_OP    = 8'b1110_0000;
  localparam logic [OP_W-1:0] EXE_LH_OP    = 8'b1110_0001;
  localparam logic [OP_W-1:0] EXE_LW_OP    = 8'b1110_0011;
  localparam logic [OP_W-1:0] EXE_LBU_OP   = 8'b1110_0100;
  localparam logic [OP_W-1:0] EXE_LHU_OP   = 8'b1110_0101;
  localparam logic [OP_W-1:0] EXE_SB_OP    = 8'b1110_1000;
  localparam logic [OP_W-1:0] EXE_SH_OP    = 8'b1110_1001;
  localparam logic [OP_W-1:0] EXE_SW_OP    = 8'b1110_1011;

  // Multi-cycle multiply-accumulate op codes that use the hilo/cnt loop-back
  localparam logic [OP_W-1:0] EXE_MADD_OP  = 8'b1010_1000;
  localparam logic [OP_W-1:0] EXE_MADDU_OP = 8'b1010_1001;
  localparam logic [OP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [OP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

endpackage

// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline bus: EX-stage results in, MEM-stage copies plus MADD/MSUB loop-back out.
interface ex_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 8
);
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic                ex_whilo;
  logic [OP_W-1:0]     ex_aluop;
  logic [DATA_W-1:0]   ex_mem_addr;
  logic [DATA_W-1:0]   ex_reg2;
  logic [2*DATA_W-1:0] hilo_i;
  logic [1:0]          cnt_i;

  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_whilo;
  logic [OP_W-1:0]     mem_aluop;
  logic [DATA_W-1:0]   mem_mem_addr;
  logic [DATA_W-1:0]   mem_reg2;
  logic [2*DATA_W-1:0] hilo_o;
  logic [1:0]          cnt_o;

  // EX stage side
  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );

  // Pipeline register side
  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
           ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with pass/bubble/hold/flush control and the MADD/MSUB partial-product loop-back.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_if.slave            bus
);

  logic [ADDR_W-1:0]   wd_q;
  logic                wreg_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                whilo_q;
  logic [OP_W-1:0]     aluop_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   reg2_q;
  logic [2*DATA_W-1:0] hilo_q;
  logic [1:0]          cnt_q;

  logic                unused_stall;
  logic                stall_ex;
  logic                stall_mem;

  assign stall_ex     = stall[STALL_EX];
  assign stall_mem    = stall[STALL_MEM];
  assign unused_stall = ^{stall[STALL_WB], stall[STALL_ID], stall[STALL_IF], stall[STALL_PC]};

  // Mode decode in priority order: reset, flush, bubble, hold, pass.
  // stall_ex=0 with stall_mem=1 falls through to pass.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wd_q       <= '0;
      wreg_q     <= WriteDisable;
      wdata_q    <= DATA_W'(ZeroWord);
      hi_q       <= DATA_W'(ZeroWord);
      lo_q       <= DATA_W'(ZeroWord);
      whilo_q    <= WriteDisable;
      aluop_q    <= '0;
      mem_addr_q <= DATA_W'(ZeroWord);
      reg2_q     <= DATA_W'(ZeroWord);
      hilo_q     <= '0;
      cnt_q      <= 2'd0;
    end else if (stall_ex && !stall_mem) begin
      // EX is busy (e.g. MADD in flight): inject a bubble, park the partial product
      wd_q       <= '0;
      wreg_q     <= WriteDisable;
      wdata_q    <= DATA_W'(ZeroWord);
      hi_q       <= DATA_W'(ZeroWord);
      lo_q       <= DATA_W'(ZeroWord);
      whilo_q    <= WriteDisable;
      aluop_q    <= '0;
      mem_addr_q <= DATA_W'(ZeroWord);
      reg2_q     <= DATA_W'(ZeroWord);
      hilo_q     <= bus.hilo_i;
      cnt_q      <= bus.cnt_i;
    end else if (!stall_ex) begin
      wd_q       <= bus.ex_wd;
      wreg_q     <= bus.ex_wreg;
      wdata_q    <= bus.ex_wdata;
      hi_q       <= bus.ex_hi;
      lo_q       <= bus.ex_lo;
      whilo_q    <= bus.ex_whilo;
      aluop_q    <= bus.ex_aluop;
      mem_addr_q <= bus.ex_mem_addr;
      reg2_q     <= bus.ex_reg2;
      hilo_q     <= '0;
      cnt_q      <= 2'd0;
    end
  end

  assign bus.mem_wd       = wd_q;
  assign bus.mem_wreg     = wreg_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_hi       = hi_q;
  assign bus.mem_lo       = lo_q;
  assign bus.mem_whilo    = whilo_q;
  assign bus.mem_aluop    = aluop_q;
  assign bus.mem_mem_addr = mem_addr_q;
  assign bus.mem_reg2     = reg2_q;
  assign bus.hilo_o       = hilo_q;
  assign bus.cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: directed steps push hand-computed expectations, a monitor checks after each edge.
module tb_ex_mem;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 8;

  typedef struct packed {
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                whilo;
    logic [OP_W-1:0]     aluop;
    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   reg2;
    logic [2*DATA_W-1:0] hilo;
    logic [1:0]          cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [5:0] stall;
  logic       flush;

  ex_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

  ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic vec_t v(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                             input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                             input logic [7:0] aluop, input logic [31:0] addr, input logic [31:0] reg2,
                             input logic [63:0] hilo, input logic [1:0] cnt);
    vec_t r;
    r = '{wd, wreg, wdata, hi, lo, whilo, aluop, addr, reg2, hilo, cnt};
    return r;
  endfunction

  function automatic vec_t dut_out();
    vec_t r;
    r = '{bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_hi, bus.mem_lo, bus.mem_whilo,
          bus.mem_aluop, bus.mem_mem_addr, bus.mem_reg2, bus.hilo_o, bus.cnt_o};
    return r;
  endfunction

  task automatic drive(input vec_t d);
    bus.ex_wd       = d.wd;
    bus.ex_wreg     = d.wreg;
    bus.ex_wdata    = d.wdata;
    bus.ex_hi       = d.hi;
    bus.ex_lo       = d.lo;
    bus.ex_whilo    = d.whilo;
    bus.ex_aluop    = d.aluop;
    bus.ex_mem_addr = d.addr;
    bus.ex_reg2     = d.reg2;
    bus.hilo_i      = d.hilo;
    bus.cnt_i       = d.cnt;
  endtask

  // One clock of stimulus; the expectation describes outputs after the next rising edge
  task automatic step(input string nm, input logic r, input logic [5:0] s, input logic f,
                      input vec_t d, input vec_t e);
    @(negedge clk);
    rst   = r;
    stall = s;
    flush = f;
    drive(d);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle, checked 1 time unit after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        vec_t  e;
        vec_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = dut_out();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got wd=%0h wreg=%0b wdata=%h hi=%h lo=%h whilo=%0b op=%h addr=%h reg2=%h hilo=%h cnt=%0d exp wd=%0h wreg=%0b wdata=%h hi=%h lo=%h whilo=%0b op=%h addr=%h reg2=%h hilo=%h cnt=%0d",
                   nm, a.wd, a.wreg, a.wdata, a.hi, a.lo, a.whilo, a.aluop, a.addr, a.reg2, a.hilo, a.cnt,
                   e.wd, e.wreg, e.wdata, e.hi, e.lo, e.whilo, e.aluop, e.addr, e.reg2, e.hilo, e.cnt);
        end
      end
    end
  end

  vec_t zero_v;
  vec_t in_a;
  vec_t in_b;
  vec_t in_c;
  vec_t in_h;

  initial begin
    zero_v = '0;
    rst    = 1'b1;
    stall  = 6'b000000;
    flush  = 1'b0;
    drive(zero_v);

    in_a = v(5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 8'hE3, 32'h0000_0100, 32'h0000_0042,
             64'h0000_0000_0000_0077, 2'd2);
    in_b = v(5'd3, 1'b1, 32'h0000_AAAA, 32'h1111, 32'h2222, 1'b0, 8'hEB, 32'h0000_0200, 32'h0000_00FF,
             64'h0, 2'd0);
    in_c = v(5'd7, 1'b1, 32'h0000_5555, 32'h3333, 32'h4444, 1'b1, 8'hE0, 32'h0000_0300, 32'h0000_0011,
             64'h0000_0000_0000_0099, 2'd3);
    in_h = v(5'd0, 1'b0, 32'h0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 8'h00, 32'h0, 32'h0, 64'h0, 2'd0);

    step("reset",        1'b1, 6'b000000, 1'b0, in_a, zero_v);
    step("pass",         1'b0, 6'b000000, 1'b0, in_a,
         v(5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 8'hE3, 32'h0000_0100, 32'h0000_0042, 64'h0, 2'd0));
    step("bubble",       1'b0, 6'b001111, 1'b0,
         v(5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 1'b0, 8'hA8, 32'h100, 32'h42, 64'h0000_0001_FFFF_FFFE, 2'd1),
         v(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0000_0001_FFFF_FFFE, 2'd1));
    step("flush_beats_stall", 1'b0, 6'b011111, 1'b1,
         v(5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 1'b0, 8'hA8, 32'h100, 32'h42, 64'h0000_0001_FFFF_FFFE, 2'd1),
         zero_v);

    step("load_aaaa",    1'b0, 6'b000000, 1'b0, in_b,
         v(5'd3, 1'b1, 32'h0000_AAAA, 32'h1111, 32'h2222, 1'b0, 8'hEB, 32'h0000_0200, 32'h0000_00FF, 64'h0, 2'd0));
    for (int i = 0; i < 3; i++) begin
      step($sformatf("hold_%0d", i), 1'b0, 6'b011111, 1'b0, in_c,
           v(5'd3, 1'b1, 32'h0000_AAAA, 32'h1111, 32'h2222, 1'b0, 8'hEB, 32'h0000_0200, 32'h0000_00FF, 64'h0, 2'd0));
    end

    step("bubble_madd",  1'b0, 6'b001111, 1'b0, in_c,
         v(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0000_0000_0000_0099, 2'd3));
    step("hold_keeps_hilo", 1'b0, 6'b011111, 1'b0, in_a,
         v(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0000_0000_0000_0099, 2'd3));
    step("rst_mid_madd", 1'b1, 6'b001111, 1'b0, in_c, zero_v);

    step("illegal_stall_pass", 1'b0, 6'b010000, 1'b0, in_c,
         v(5'd7, 1'b1, 32'h0000_5555, 32'h3333, 32'h4444, 1'b1, 8'hE0, 32'h0000_0300, 32'h0000_0011, 64'h0, 2'd0));
    step("pass_before_rst", 1'b0, 6'b000000, 1'b0, in_a,
         v(5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 8'hE3, 32'h0000_0100, 32'h0000_0042, 64'h0, 2'd0));
    step("rst_in_traffic", 1'b1, 6'b000000, 1'b0, in_a, zero_v);
    step("resume_after_rst", 1'b0, 6'b000000, 1'b0, in_a,
         v(5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 8'hE3, 32'h0000_0100, 32'h0000_0042, 64'h0, 2'd0));

    step("hilo_write",   1'b0, 6'b000000, 1'b0, in_h,
         v(5'd0, 1'b0, 32'h0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 8'h00, 32'h0, 32'h0, 64'h0, 2'd0));
    step("hilo_write_off", 1'b0, 6'b000000, 1'b0, zero_v, zero_v);

    step("pass_again",   1'b0, 6'b000000, 1'b0, in_b,
         v(5'd3, 1'b1, 32'h0000_AAAA, 32'h1111, 32'h2222, 1'b0, 8'hEB, 32'h0000_0200, 32'h0000_00FF, 64'h0, 2'd0));
    step("flush_no_stall", 1'b0, 6'b000000, 1'b1, in_b, zero_v);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
